// File: rtl/seq_divider_32b_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
// The master side issues divisions; the slave side is the divider itself.
interface seq_divider_32b_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] Q;
    logic [SIZE-1:0] R;
    logic            div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, div_by_zero
    );
endinterface

// File: rtl/seq_divider_32b.sv
// Unsigned iterative restoring divider: one quotient bit per clock.
// Results stay on Q/R/div_by_zero from the done pulse until the next result or reset.
module seq_divider_32b #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    seq_divider_32b_if.slave  bus
);
    localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   dvd_q, dvd_d;
    logic [SIZE-1:0]   dsr_q, dsr_d;
    logic [SIZE-1:0]   rem_q, rem_d;
    logic [SIZE-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   q_out_q, q_out_d;
    logic [SIZE-1:0]   r_out_q, r_out_d;
    logic              dbz_q, dbz_d;

    logic [SIZE:0]     rem_shift;
    logic [SIZE:0]     diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        q_out_d   = q_out_q;
        r_out_d   = r_out_q;
        dbz_d     = dbz_q;
        // One extra bit on the trial subtraction: its MSB is the borrow.
        rem_shift = {rem_q, dvd_q[SIZE-1]};
        diff      = rem_shift - {1'b0, dsr_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    dvd_d = bus.A;
                    dsr_d = bus.B;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (bus.B == '0) begin
                        state_d = DONE;
                        q_out_d = '1;
                        r_out_d = bus.A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dvd_d = dvd_q << 1;
                if (!diff[SIZE]) begin
                    rem_d = diff[SIZE-1:0];
                    quo_d = {quo_q[SIZE-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[SIZE-1:0];
                    quo_d = {quo_q[SIZE-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SIZE - 1)) begin
                    state_d = DONE;
                    q_out_d = quo_d;
                    r_out_d = rem_d;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.Q           = q_out_q;
    assign bus.R           = r_out_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_32b.sv
// Directed checks of the sequential divider: latency, handshake, corner operands,
// divide-by-zero, back-to-back starts, mid-run reset and the A == Q*B + R invariant.
module tb_seq_divider_32b;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    seq_divider_32b_if #(.SIZE(32)) bus ();

    seq_divider_32b #(.SIZE(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a negedge; the next rising edge is the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts edges from the accepting edge (edge 1) until done is seen, bounded.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 1;
        busy_cycles = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.Q !== 32'd0 || bus.R !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: busy=%b done=%b dbz=%b Q=%h R=%h, required all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.Q, bus.R);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int edges, busy_cycles;
        issue(32'd100, 32'd7);
        wait_done(edges, busy_cycles);
        vectors++;
        if (edges !== 33) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got %0d edges, required 33", edges);
        end
        vectors++;
        if (busy_cycles !== 32) begin
            miscompares++;
            $display("[TB] FAIL basic_busy: busy for %0d cycles, required 32", busy_cycles);
        end
        vectors++;
        if (bus.Q !== 32'd14 || bus.R !== 32'd2 || bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_100_7: Q=%0d R=%0d dbz=%b, required Q=14 R=2 dbz=0",
                     bus.Q, bus.R, bus.div_by_zero);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== 32'd14 || bus.R !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL basic_hold: done=%b busy=%b Q=%0d R=%0d, required 0 0 14 2",
                     bus.done, bus.busy, bus.Q, bus.R);
        end
    endtask

    task automatic test_corners();
        int edges, busy_cycles;
        issue(32'hFFFF_FFFF, 32'd1);
        wait_done(edges, busy_cycles);
        vectors++;
        if (bus.Q !== 32'hFFFF_FFFF || bus.R !== 32'd0 || edges !== 33) begin
            miscompares++;
            $display("[TB] FAIL full_range: Q=%h R=%h edges=%0d, required Q=ffffffff R=0 edges=33",
                     bus.Q, bus.R, edges);
        end
        @(negedge clk);
        issue(32'd5, 32'hFFFF_FFFF);
        wait_done(edges, busy_cycles);
        vectors++;
        if (bus.Q !== 32'd0 || bus.R !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL a_lt_b: Q=%0d R=%0d, required Q=0 R=5", bus.Q, bus.R);
        end
        @(negedge clk);
        issue(32'd77, 32'd77);
        wait_done(edges, busy_cycles);
        vectors++;
        if (bus.Q !== 32'd1 || bus.R !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL a_eq_b: Q=%0d R=%0d, required Q=1 R=0", bus.Q, bus.R);
        end
        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'h0001_0000);
        wait_done(edges, busy_cycles);
        vectors++;
        if (bus.Q !== 32'h0000_DEAD || bus.R !== 32'h0000_BEEF) begin
            miscompares++;
            $display("[TB] FAIL shift_div: Q=%h R=%h, required Q=0000dead R=0000beef", bus.Q, bus.R);
        end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        int edges, busy_cycles;
        issue(32'd1234, 32'd0);
        wait_done(edges, busy_cycles);
        vectors++;
        if (edges !== 1 || busy_cycles !== 0) begin
            miscompares++;
            $display("[TB] FAIL dbz_latency: edges=%0d busy=%0d, required edges=1 busy=0", edges, busy_cycles);
        end
        vectors++;
        if (bus.Q !== 32'hFFFF_FFFF || bus.R !== 32'd1234 || bus.div_by_zero !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL dbz_result: Q=%h R=%0d dbz=%b, required Q=ffffffff R=1234 dbz=1",
                     bus.Q, bus.R, bus.div_by_zero);
        end
        @(negedge clk);
        vectors++;
        if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dbz_hold: dbz=%b done=%b, required dbz=1 done=0", bus.div_by_zero, bus.done);
        end
        issue(32'd9, 32'd3);
        wait_done(edges, busy_cycles);
        vectors++;
        if (bus.Q !== 32'd3 || bus.R !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dbz_clear: Q=%0d R=%0d dbz=%b, required Q=3 R=0 dbz=0",
                     bus.Q, bus.R, bus.div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int edges, busy_cycles;
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        edges       = 11;
        busy_cycles = 10;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        vectors++;
        if (edges !== 33 || bus.Q !== 32'd14 || bus.R !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL ignore_start: edges=%0d Q=%0d R=%0d, required edges=33 Q=14 R=2",
                     edges, bus.Q, bus.R);
        end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_no_queue: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_cycles;
        issue(32'd100, 32'd7);
        wait_done(edges, busy_cycles);
        issue(32'd50, 32'd5);
        vectors++;
        if (bus.busy !== 1'b1 || bus.Q !== 32'd14) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: busy=%b Q=%0d, required busy=1 Q=14", bus.busy, bus.Q);
        end
        wait_done(edges, busy_cycles);
        vectors++;
        if (edges !== 33 || bus.Q !== 32'd10 || bus.R !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: edges=%0d Q=%0d R=%0d, required edges=33 Q=10 R=0",
                     edges, bus.Q, bus.R);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        issue(32'd100, 32'd7);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.Q !== 32'd0 || bus.R !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_run: busy=%b done=%b dbz=%b Q=%h R=%h, required all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.Q, bus.R);
        end
        @(negedge clk);
        reset     = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: %0d cycles with done/busy after reset, required 0", done_seen);
        end
    endtask

    task automatic test_random();
        int          edges, busy_cycles;
        logic [31:0] a, b;
        logic [63:0] recomposed;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
            if (b == 32'd0) b = 32'd1;
            issue(a, b);
            wait_done(edges, busy_cycles);
            recomposed = {32'd0, bus.Q} * {32'd0, b} + {32'd0, bus.R};
            vectors++;
            if (recomposed !== {32'd0, a} || bus.R >= b || edges !== 33) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: A=%h B=%h Q=%h R=%h edges=%0d, required Q*B+R==A, R<B, 33 edges",
                         i, a, b, bus.Q, bus.R, edges);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_corners();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
